// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter.
//   mem_load_type_t / mem_store_type_t : access size encodings of the data memory
//   arb_state_t                        : arbiter FSM states
//   arb_req_id_t                       : requester identity (CPU / DMA)
//   mem_req_t                          : one latched request payload
//   misaligned()                       : alignment rule for a load/store size pair
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      NO_LOAD    = 2'd0,
      LOAD_BYTE  = 2'd1,
      LOAD_WORD  = 2'd2,
      LOAD_DWORD = 2'd3
   } mem_load_type_t;

   typedef enum logic [1:0] {
      NO_STORE    = 2'd0,
      STORE_BYTE  = 2'd1,
      STORE_WORD  = 2'd2,
      STORE_DWORD = 2'd3
   } mem_store_type_t;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_RESP   = 2'd2
   } arb_state_t;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_DMA = 1'b1
   } arb_req_id_t;

   typedef struct packed {
      logic [63:0]     addr;
      logic [63:0]     wdata;
      mem_load_type_t  ld;
      mem_store_type_t st;
      logic            sgn;
   } mem_req_t;

   // Load and store encodings share the same size ordering, so the larger
   // of the two is simply the numerically larger code.
   function automatic logic misaligned(input logic [2:0] addr_lo,
                                       input mem_load_type_t ld,
                                       input mem_store_type_t st);
      logic [1:0] l, s, sz;
      l  = ld;
      s  = st;
      sz = (l > s) ? l : s;
      case (sz)
         2'd2:    misaligned = (addr_lo[1:0] != 2'b00);
         2'd3:    misaligned = (addr_lo != 3'b000);
         default: misaligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, reset : clock, asynchronous active-low reset
//   enable     : arbitration allowed this cycle (port idle)
//   req[1:0]   : request valids, bit 0 = CPU, bit 1 = DMA
//   gnt[1:0]   : one-hot combinational grant (zero when disabled / no request)
// Since a grant is only ever given to a valid requester, a nonzero grant is
// exactly a completed handshake, which is when last_grant advances.
module rr_arbiter2
   import mem_port_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   arb_req_id_t last_grant;

   always_comb begin
      gnt = 2'b00;
      if (enable) begin
         if (req == 2'b11) gnt = (last_grant == REQ_DMA) ? 2'b01 : 2'b10;
         else              gnt = req;
      end
   end

   // Reset to DMA so the CPU wins the first tie.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      last_grant <= REQ_DMA;
      else if (|gnt)   last_grant <= gnt[1] ? REQ_DMA : REQ_CPU;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single data-memory port between the CPU MEM stage and a
// DMA/debug loader.
//   clk, reset              : clock, asynchronous active-low reset
//   cpu_* / dma_*           : valid/ready request channel plus one-cycle
//                             response pulse (resp_valid, resp_err, rdata)
//   mem_*                   : drive the data memory; mem_rdata is its
//                             combinational read data
//   busy                    : FSM not in IDLE
// Parameters: WAIT_CYCLES extra ACCESS cycles (0..15), ALIGN_CHECK rejects
// misaligned word/dword requests with an error response.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 0,
   parameter bit          ALIGN_CHECK = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cpu_req_valid,
   output logic            cpu_req_ready,
   input  logic [63:0]     cpu_addr,
   input  logic [63:0]     cpu_wdata,
   input  mem_load_type_t  cpu_load_type,
   input  mem_store_type_t cpu_store_type,
   input  logic            cpu_signed,
   output logic            cpu_resp_valid,
   output logic            cpu_resp_err,
   output logic [63:0]     cpu_rdata,
   input  logic            dma_req_valid,
   output logic            dma_req_ready,
   input  logic [63:0]     dma_addr,
   input  logic [63:0]     dma_wdata,
   input  mem_load_type_t  dma_load_type,
   input  mem_store_type_t dma_store_type,
   input  logic            dma_signed,
   output logic            dma_resp_valid,
   output logic            dma_resp_err,
   output logic [63:0]     dma_rdata,
   output logic [63:0]     mem_addr,
   output logic [63:0]     mem_wdata,
   output logic            mem_signed,
   output mem_load_type_t  mem_load_type,
   output mem_store_type_t mem_store_type,
   input  logic [63:0]     mem_rdata,
   output logic            busy
);

   localparam logic [1:0] ST_IDLE   = ARB_IDLE;
   localparam logic [1:0] ST_ACCESS = ARB_ACCESS;
   localparam logic [1:0] ST_RESP   = ARB_RESP;

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic [1:0]  gnt;
   logic        accept, bad, err_q;
   arb_req_id_t owner;
   mem_req_t    sel, cur;
   logic [63:0] load_data;

   // Gating with reset keeps both readies low while reset is held.
   rr_arbiter2 u_arb (
      .clk    (clk),
      .reset  (reset),
      .enable (state == ST_IDLE && reset),
      .req    ({dma_req_valid, cpu_req_valid}),
      .gnt    (gnt)
   );

   assign cpu_req_ready = gnt[0];
   assign dma_req_ready = gnt[1];
   assign accept        = |gnt;

   always_comb begin
      if (gnt[1]) sel = '{addr: dma_addr, wdata: dma_wdata, ld: dma_load_type,
                          st: dma_store_type, sgn: dma_signed};
      else        sel = '{addr: cpu_addr, wdata: cpu_wdata, ld: cpu_load_type,
                          st: cpu_store_type, sgn: cpu_signed};
   end

   assign bad       = ALIGN_CHECK && misaligned(sel.addr[2:0], sel.ld, sel.st);
   assign load_data = (cur.ld == NO_LOAD) ? 64'd0 : mem_rdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         cnt       <= 4'd0;
         cur       <= '0;
         owner     <= REQ_CPU;
         err_q     <= 1'b0;
         cpu_rdata <= 64'd0;
         dma_rdata <= 64'd0;
      end else begin
         case (state)
            ST_IDLE: if (accept) begin
               cur   <= sel;
               owner <= gnt[1] ? REQ_DMA : REQ_CPU;
               cnt   <= 4'(WAIT_CYCLES);
               err_q <= bad;
               if (bad) begin
                  // Rejected requests skip ACCESS entirely: no memory activity.
                  state <= ST_RESP;
                  if (gnt[1]) dma_rdata <= 64'd0;
                  else        cpu_rdata <= 64'd0;
               end else begin
                  state <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (cnt == 4'd0) begin
                  state <= ST_RESP;
                  if (owner == REQ_DMA) dma_rdata <= load_data;
                  else                  cpu_rdata <= load_data;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // The store strobe appears only in the final ACCESS cycle; the memory
   // writes on the following negedge, so each store writes exactly once and
   // an async reset before that negedge drops it.
   always_comb begin
      mem_addr       = 64'd0;
      mem_wdata      = 64'd0;
      mem_signed     = 1'b0;
      mem_load_type  = NO_LOAD;
      mem_store_type = NO_STORE;
      if (state == ST_ACCESS) begin
         mem_addr      = cur.addr;
         mem_wdata     = cur.wdata;
         mem_signed    = cur.sgn;
         mem_load_type = cur.ld;
         if (cnt == 4'd0) mem_store_type = cur.st;
      end
   end

   assign cpu_resp_valid = (state == ST_RESP) && (owner == REQ_CPU);
   assign dma_resp_valid = (state == ST_RESP) && (owner == REQ_DMA);
   assign cpu_resp_err   = cpu_resp_valid & err_q;
   assign dma_resp_err   = dma_resp_valid & err_q;
   assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, multi-cycle
// corner sequences and randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int W = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic            cpu_req_valid, cpu_req_ready, cpu_signed, cpu_resp_valid, cpu_resp_err;
   logic [63:0]     cpu_addr, cpu_wdata, cpu_rdata;
   mem_load_type_t  cpu_load_type;
   mem_store_type_t cpu_store_type;
   logic            dma_req_valid, dma_req_ready, dma_signed, dma_resp_valid, dma_resp_err;
   logic [63:0]     dma_addr, dma_wdata, dma_rdata;
   mem_load_type_t  dma_load_type;
   mem_store_type_t dma_store_type;
   logic [63:0]     mem_addr, mem_wdata, mem_rdata;
   logic            mem_signed, busy;
   mem_load_type_t  mem_load_type;
   mem_store_type_t mem_store_type;

   mem_port_arbiter #(.WAIT_CYCLES(W), .ALIGN_CHECK(1)) dut (
      .clk(clk), .reset(reset),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_load_type(cpu_load_type),
      .cpu_store_type(cpu_store_type), .cpu_signed(cpu_signed),
      .cpu_resp_valid(cpu_resp_valid), .cpu_resp_err(cpu_resp_err), .cpu_rdata(cpu_rdata),
      .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
      .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_load_type(dma_load_type),
      .dma_store_type(dma_store_type), .dma_signed(dma_signed),
      .dma_resp_valid(dma_resp_valid), .dma_resp_err(dma_resp_err), .dma_rdata(dma_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_signed(mem_signed),
      .mem_load_type(mem_load_type), .mem_store_type(mem_store_type),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic int ld_bytes(input mem_load_type_t t);
      case (t)
         LOAD_BYTE:  return 1;
         LOAD_WORD:  return 4;
         LOAD_DWORD: return 8;
         default:    return 0;
      endcase
   endfunction

   function automatic int st_bytes(input mem_store_type_t t);
      case (t)
         STORE_BYTE:  return 1;
         STORE_WORD:  return 4;
         STORE_DWORD: return 8;
         default:     return 0;
      endcase
   endfunction

   // Data memory: little-endian, writes on negedge, combinational read with
   // size selection and optional sign extension.
   logic [7:0] ram [0:1023] = '{default: 8'h00};

   always @(negedge clk) begin
      for (int i = 0; i < st_bytes(mem_store_type); i++)
         ram[10'(mem_addr[9:0] + 10'(i))] <= mem_wdata[8*i +: 8];
   end

   always_comb begin
      logic [63:0] v;
      int n;
      v = 64'd0;
      n = ld_bytes(mem_load_type);
      for (int i = 0; i < 8; i++)
         if (i < n) v[8*i +: 8] = ram[10'(mem_addr[9:0] + 10'(i))];
      if (mem_signed && n > 0 && n < 8 && v[8*n-1])
         for (int i = 0; i < 8; i++)
            if (i >= n) v[8*i +: 8] = 8'hFF;
      mem_rdata = v;
   end

   // Transaction-level reference: a byte-array shadow memory updated per
   // accepted request, values computed arithmetically.
   logic [7:0] ref_mem [0:1023] = '{default: 8'h00};

   function automatic void model(input logic [63:0] a, input logic [63:0] wd,
                                 input mem_load_type_t ld, input mem_store_type_t st,
                                 input logic sg, output logic [63:0] rd, output logic er);
      int lb, sb, m;
      lb = ld_bytes(ld);
      sb = st_bytes(st);
      m  = (lb > sb) ? lb : sb;
      rd = 64'd0;
      er = (m > 1) && ((a % 64'(m)) != 64'd0);
      if (er) return;
      for (int i = 0; i < sb; i++) ref_mem[10'(a[9:0] + 10'(i))] = wd[8*i +: 8];
      for (int i = 0; i < lb; i++) rd[8*i +: 8] = ref_mem[10'(a[9:0] + 10'(i))];
      if (sg && lb > 0 && lb < 8 && rd[8*lb-1]) rd = rd - (64'd1 << (8*lb));
   endfunction

   int checks = 0;
   int errors = 0;
   logic [63:0] last_rd [2] = '{64'd0, 64'd0};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic d, input logic v, input logic [63:0] a, input logic [63:0] wd,
                        input mem_load_type_t ld, input mem_store_type_t st, input logic sg);
      if (d) begin
         dma_req_valid = v; dma_addr = a; dma_wdata = wd;
         dma_load_type = ld; dma_store_type = st; dma_signed = sg;
      end else begin
         cpu_req_valid = v; cpu_addr = a; cpu_wdata = wd;
         cpu_load_type = ld; cpu_store_type = st; cpu_signed = sg;
      end
   endtask

   // One complete request: handshake, latency, response data, store strobe
   // count, pulse width and hold of the other requester's rdata.
   task automatic do_req(input string nm, input logic d, input logic [63:0] a, input logic [63:0] wd,
                         input mem_load_type_t ld, input mem_store_type_t st, input logic sg,
                         input logic [63:0] exp_rd, input logic exp_er);
      int n, lat, nst, exp_lat;
      logic got, rdy, ldact, spur, er;
      logic [63:0] rd, oth;
      mem_store_type_t st_seen;
      @(posedge clk); #1;
      drive(d, 1'b1, a, wd, ld, st, sg);
      #1;
      n = 0;
      rdy = d ? dma_req_ready : cpu_req_ready;
      while (!rdy && n < 20) begin
         @(posedge clk); #2;
         rdy = d ? dma_req_ready : cpu_req_ready;
         n++;
      end
      chk({nm, "_ready"}, 64'(rdy), 64'd1);
      if (!rdy) begin
         drive(d, 1'b0, a, wd, ld, st, sg);
         return;
      end
      @(posedge clk); #1;
      drive(d, 1'b0, a, wd, ld, st, sg);
      got = 0; lat = 0; nst = 0; ldact = 0; spur = 0; rd = '0; er = 0; oth = '0;
      st_seen = NO_STORE;
      for (int k = 1; k <= W + 6 && !got; k++) begin
         @(negedge clk);
         if (mem_store_type != NO_STORE) begin nst++; st_seen = mem_store_type; end
         if (mem_load_type != NO_LOAD) ldact = 1;
         if (d ? cpu_resp_valid : dma_resp_valid) spur = 1;
         if (d ? dma_resp_valid : cpu_resp_valid) begin
            got = 1; lat = k;
            rd  = d ? dma_rdata : cpu_rdata;
            er  = d ? dma_resp_err : cpu_resp_err;
            oth = d ? cpu_rdata : dma_rdata;
         end
      end
      exp_lat = exp_er ? 1 : W + 2;
      chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({nm, "_rdata"}, rd, exp_rd);
      chk({nm, "_err"}, 64'(er), 64'(exp_er));
      chk({nm, "_stores"}, 64'(nst), (exp_er || st == NO_STORE) ? 64'd0 : 64'd1);
      if (nst == 1) chk({nm, "_store_type"}, 64'(st_seen), 64'(st));
      if (exp_er) chk({nm, "_no_load"}, 64'(ldact), 64'd0);
      chk({nm, "_other_resp"}, 64'(spur), 64'd0);
      chk({nm, "_other_hold"}, oth, last_rd[d ? 0 : 1]);
      last_rd[d ? 1 : 0] = exp_rd;
      @(negedge clk);
      chk({nm, "_pulse"}, 64'(d ? dma_resp_valid : cpu_resp_valid), 64'd0);
   endtask

   typedef struct {
      logic            d;
      logic [63:0]     addr;
      logic [63:0]     wdata;
      mem_load_type_t  ld;
      mem_store_type_t st;
      logic            sg;
      logic [63:0]     exp_rd;
      logic            exp_er;
   } vec_t;

   vec_t tbl [15];

   initial begin
      logic q [$];
      int cnt_a, cnt_b, cnt_c, cnt_d;
      logic [63:0] e_rd;
      logic e_er;

      tbl[0]  = '{1'b0, 64'h100, 64'h1122334455667788, NO_LOAD,    STORE_DWORD, 1'b0, 64'h0, 1'b0};
      tbl[1]  = '{1'b0, 64'h100, 64'h0,                LOAD_DWORD, NO_STORE,    1'b0, 64'h1122334455667788, 1'b0};
      tbl[2]  = '{1'b1, 64'h040, 64'hDEADBEEFCAFEF00D, NO_LOAD,    STORE_WORD,  1'b0, 64'h0, 1'b0};
      tbl[3]  = '{1'b1, 64'h040, 64'h0,                LOAD_WORD,  NO_STORE,    1'b0, 64'h00000000CAFEF00D, 1'b0};
      tbl[4]  = '{1'b0, 64'h040, 64'h0,                LOAD_WORD,  NO_STORE,    1'b1, 64'hFFFFFFFFCAFEF00D, 1'b0};
      tbl[5]  = '{1'b0, 64'h042, 64'h0,                LOAD_WORD,  NO_STORE,    1'b0, 64'h0, 1'b1};
      tbl[6]  = '{1'b1, 64'h043, 64'h5555555555555580, NO_LOAD,    STORE_BYTE,  1'b0, 64'h0, 1'b0};
      tbl[7]  = '{1'b0, 64'h043, 64'h0,                LOAD_BYTE,  NO_STORE,    1'b1, 64'hFFFFFFFFFFFFFF80, 1'b0};
      tbl[8]  = '{1'b0, 64'h043, 64'h0,                LOAD_BYTE,  NO_STORE,    1'b0, 64'h0000000000000080, 1'b0};
      tbl[9]  = '{1'b1, 64'h104, 64'hFFFFFFFFFFFFFFFF, NO_LOAD,    STORE_DWORD, 1'b0, 64'h0, 1'b1};
      tbl[10] = '{1'b0, 64'h007, 64'h0,                NO_LOAD,    NO_STORE,    1'b0, 64'h0, 1'b0};
      tbl[11] = '{1'b1, 64'h100, 64'h0,                LOAD_DWORD, NO_STORE,    1'b0, 64'h1122334455667788, 1'b0};
      tbl[12] = '{1'b1, 64'h044, 64'h0,                LOAD_BYTE,  STORE_DWORD, 1'b0, 64'h0, 1'b1};
      tbl[13] = '{1'b0, 64'h040, 64'h0,                LOAD_WORD,  NO_STORE,    1'b0, 64'h0000000080FEF00D, 1'b0};
      tbl[14] = '{1'b0, 64'h040, 64'h0,                LOAD_WORD,  NO_STORE,    1'b1, 64'hFFFFFFFF80FEF00D, 1'b0};

      // Reset state, with both requesters asserting valid during reset.
      reset = 1'b0;
      drive(1'b0, 1'b1, 64'h0, 64'h0, NO_LOAD, NO_STORE, 1'b0);
      drive(1'b1, 1'b1, 64'h0, 64'h0, NO_LOAD, NO_STORE, 1'b0);
      #12;
      chk("rst_ready", {62'd0, cpu_req_ready, dma_req_ready}, 64'd0);
      chk("rst_resp", {60'd0, cpu_resp_valid, dma_resp_valid, cpu_resp_err, dma_resp_err}, 64'd0);
      chk("rst_cpu_rdata", cpu_rdata, 64'd0);
      chk("rst_dma_rdata", dma_rdata, 64'd0);
      chk("rst_mem_addr", mem_addr, 64'd0);
      chk("rst_mem_wdata", mem_wdata, 64'd0);
      chk("rst_mem_ctl", {59'd0, mem_signed, mem_load_type, mem_store_type}, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      drive(1'b0, 1'b0, 64'h0, 64'h0, NO_LOAD, NO_STORE, 1'b0);
      drive(1'b1, 1'b0, 64'h0, 64'h0, NO_LOAD, NO_STORE, 1'b0);
      @(posedge clk); #1 reset = 1'b1;

      for (int i = 0; i < 15; i++)
         do_req($sformatf("vec%0d", i), tbl[i].d, tbl[i].addr, tbl[i].wdata,
                tbl[i].ld, tbl[i].st, tbl[i].sg, tbl[i].exp_rd, tbl[i].exp_er);

      // Tie: fresh reset, both valid continuously -> CPU, DMA, CPU, DMA.
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      last_rd = '{64'd0, 64'd0};
      drive(1'b0, 1'b1, 64'h0, 64'h0, NO_LOAD, NO_STORE, 1'b0);
      drive(1'b1, 1'b1, 64'h0, 64'h0, NO_LOAD, NO_STORE, 1'b0);
      cnt_a = 0;
      for (int c = 0; c < 4 * (W + 3); c++) begin
         #1;
         if (cpu_req_ready && dma_req_ready) cnt_a++;
         if (cpu_req_ready) q.push_back(1'b0);
         if (dma_req_ready) q.push_back(1'b1);
         @(posedge clk); #1;
      end
      drive(1'b0, 1'b0, 64'h0, 64'h0, NO_LOAD, NO_STORE, 1'b0);
      drive(1'b1, 1'b0, 64'h0, 64'h0, NO_LOAD, NO_STORE, 1'b0);
      chk("tie_both_ready", 64'(cnt_a), 64'd0);
      chk("tie_grant_count", 64'(q.size()), 64'd4);
      for (int i = 0; i < 4 && i < q.size(); i++)
         chk($sformatf("tie_grant%0d", i), 64'(q[i]), 64'(i % 2));

      // Lone DMA right after a DMA grant is still granted at once.
      drive(1'b1, 1'b1, 64'h0, 64'h0, NO_LOAD, NO_STORE, 1'b0);
      #1 chk("lone_dma_ready", {62'd0, dma_req_ready, cpu_req_ready}, 64'd2);
      @(posedge clk); #1 drive(1'b1, 1'b0, 64'h0, 64'h0, NO_LOAD, NO_STORE, 1'b0);
      repeat (W + 4) @(posedge clk);

      // Reset during ACCESS of a byte store: no write, no response, IDLE.
      #1 drive(1'b0, 1'b1, 64'h10, 64'hAA, NO_LOAD, STORE_BYTE, 1'b0);
      #1 chk("midrst_ready", 64'(cpu_req_ready), 64'd1);
      @(posedge clk); #1 drive(1'b0, 1'b0, 64'h10, 64'hAA, NO_LOAD, STORE_BYTE, 1'b0);
      @(posedge clk); #1;
      chk("midrst_busy_before", 64'(busy), 64'd1);
      reset = 1'b0;
      #1;
      chk("midrst_busy_after", 64'(busy), 64'd0);
      chk("midrst_store_off", 64'(mem_store_type), 64'(NO_STORE));
      last_rd = '{64'd0, 64'd0};
      cnt_a = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (cpu_resp_valid || dma_resp_valid || mem_store_type != NO_STORE) cnt_a++;
      end
      @(posedge clk); #1 reset = 1'b1;
      for (int c = 0; c < W + 6; c++) begin
         @(negedge clk);
         if (cpu_resp_valid || dma_resp_valid || mem_store_type != NO_STORE || busy) cnt_a++;
      end
      chk("midrst_no_activity", 64'(cnt_a), 64'd0);
      chk("midrst_ram", 64'(ram[16]), 64'd0);
      do_req("midrst_readback", 1'b0, 64'h10, 64'h0, LOAD_BYTE, NO_STORE, 1'b0, 64'd0, 1'b0);

      // Withdrawal: DMA valid drops while CPU owns the port.
      @(posedge clk); #1 drive(1'b0, 1'b1, 64'h100, 64'h0, LOAD_DWORD, NO_STORE, 1'b0);
      #1 chk("wd_cpu_ready", 64'(cpu_req_ready), 64'd1);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 64'h100, 64'h0, LOAD_DWORD, NO_STORE, 1'b0);
      drive(1'b1, 1'b1, 64'h300, 64'hFFFF_FFFF_FFFF_FFFF, NO_LOAD, STORE_DWORD, 1'b0);
      cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
      for (int c = 0; c < 2; c++) begin
         #1 if (dma_req_ready) cnt_a++;
         @(posedge clk); #1;
      end
      drive(1'b1, 1'b0, 64'h300, 64'h0, NO_LOAD, NO_STORE, 1'b0);
      for (int c = 0; c < 2 * W + 8; c++) begin
         @(negedge clk);
         if (dma_resp_valid) cnt_b++;
         if (mem_store_type != NO_STORE) cnt_c++;
         if (cpu_resp_valid) begin
            cnt_d++;
            chk("wd_cpu_rdata", cpu_rdata, 64'h1122334455667788);
         end
      end
      last_rd[0] = 64'h1122334455667788;
      chk("wd_dma_ready", 64'(cnt_a), 64'd0);
      chk("wd_dma_resp", 64'(cnt_b), 64'd0);
      chk("wd_no_store", 64'(cnt_c), 64'd0);
      chk("wd_cpu_resp", 64'(cnt_d), 64'd1);
      chk("wd_ram", {ram[768], ram[769], ram[770], ram[771], ram[772], ram[773], ram[774], ram[775]}, 64'd0);

      // Randomized traffic in a private address window against the model.
      for (int it = 0; it < 150; it++) begin
         logic rd_d, rsg;
         int kind, sz;
         logic [63:0] ra, rw;
         mem_load_type_t rl;
         mem_store_type_t rs;
         rd_d = 1'($urandom_range(0, 1));
         kind = $urandom_range(0, 2);
         sz   = $urandom_range(1, 3);
         ra   = 64'h200 + 64'($urandom_range(0, 63));
         rw   = {$urandom, $urandom};
         rsg  = 1'($urandom_range(0, 1));
         rl   = (kind == 0) ? mem_load_type_t'(sz) : NO_LOAD;
         rs   = (kind == 1) ? mem_store_type_t'(sz) : NO_STORE;
         model(ra, rw, rl, rs, rsg, e_rd, e_er);
         do_req($sformatf("rnd%0d", it), rd_d, ra, rw, rl, rs, rsg, e_rd, e_er);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
